// File: rtl/serial_adder4.sv
// serial_adder4 -- bit-serial adder with valid/ready handshakes on both sides.
//
// Accepts one operand set {a, b, cin}. It adds one bit per clock, LSB first.
// The result {carry, sum} == a + b + cin is presented with a valid/ready
// output handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand set valid          in_ready   block can accept operands
//   a, b       operands (WIDTH bits)      cin        carry in
//   out_valid  sum/carry valid            out_ready  consumer accepts result
//   sum        a+b+cin mod 2^WIDTH        carry      bit WIDTH of a+b+cin
//   busy       high while in CALC or DONE
//   op_count   results consumed, wraps modulo 2^CNT_W
//
// Timing: acceptance on edge k. Bit cycles run on edges k+1 .. k+WIDTH.
// The result is loaded into DONE on edge k+WIDTH+1.
// Every output is driven straight from a flop.

module serial_adder4 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int BC_W = $clog2(WIDTH + 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_c;
    logic [BC_W-1:0]  r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [CNT_W-1:0] r_op_count;

    // One full-adder slice acting on the current LSBs
    logic w_s;
    logic w_c;
    assign w_s = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
    assign w_c = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_c) | (r_b_sh[0] & r_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_c         <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a_sh     <= a;
                        r_b_sh     <= b;
                        r_c        <= cin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    if (r_cnt == BC_LAST) begin
                        // All bits done: this cycle only loads the result
                        r_sum       <= r_sum_sh;
                        r_carry     <= r_c;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_c      <= w_c;
                        r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
                        r_a_sh   <= r_a_sh >> 1;
                        r_b_sh   <= r_b_sh >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Return to IDLE only; acceptance waits for the next edge
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_op_count  <= r_op_count + 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carry     = r_carry;
    assign busy      = r_busy;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_serial_adder4.sv
// tb_serial_adder4 -- directed, scoreboard-checked bench for serial_adder4.
// Expected {carry,sum} values are pushed when operands are accepted. They are
// popped and compared when the DUT presents a result.

module tb_serial_adder4;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
    localparam int LAT   = WIDTH + 1;  // accept edge -> out_valid edge
    localparam int ISSUE = LAT + 2;    // + consume edge + idle cycle

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    serial_adder4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int               vectors = 0;
    int               errs    = 0;
    logic [WIDTH:0]   sb[$];
    logic [CNT_W-1:0] exp_cnt = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y,
                                            input logic c);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    // Compare the presented result against the oldest scoreboard entry
    task automatic pop_check(input string tag);
        logic [WIDTH:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum_carry"}, {27'd0, carry, sum}, {27'd0, e});
        end
    endtask

    // One complete operation. With stall=1 the result is held 10 cycles first.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tc, input bit stall, input string tag);
        int n;
        logic [WIDTH-1:0] hs;
        logic hc;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        if (!in_ready) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
        out_ready = !stall;
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        tick();
        sb.push_back(model(ta, tb_, tc));
        in_valid = 1'b0;
        a = ~ta; b = ~tb_; cin = ~tc;  // later changes must not matter
        chk({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        if (tag == "first" || stall) chk({tag, "_latency"}, n, LAT);
        if (!out_valid) chk({tag, "_valid_timeout"}, 32'd0, 32'd1);
        pop_check(tag);
        if (stall) begin
            hs = sum; hc = carry;
            for (int i = 0; i < 10; i++) begin
                in_valid = i[0]; a = 4'hA; b = 4'h3; cin = 1'b1;
                tick();
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                chk("stall_hold", {27'd0, carry, sum}, {27'd0, hc, hs});
                chk("stall_count", {24'd0, op_count}, {24'd0, exp_cnt});
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        exp_cnt++;
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready_rise"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_op_count"}, {24'd0, op_count}, {24'd0, exp_cnt});
    endtask

    initial begin
        int acc;
        int last_acc;
        int cyc;
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sum_carry", {27'd0, carry, sum}, 32'd0);
        chk("rst_op_count", {24'd0, op_count}, 32'd0);

        run_op(4'd0, 4'd0, 1'b0, 1'b0, "first");
        run_op(4'd15, 4'd15, 1'b1, 1'b0, "max");
        run_op(4'd9, 4'd7, 1'b0, 1'b0, "ovf");
        run_op(4'd6, 4'd2, 1'b1, 1'b1, "stall");

        // Back-to-back: in_valid held high, operands advance after each accept
        in_valid = 1'b1; out_ready = 1'b1;
        va = 4'd1; vb = 4'd14; cin = 1'b1; a = va; b = vb;
        acc = 0; last_acc = -1; cyc = 0;
        for (int t = 0; t < 80 && (acc < 5 || sb.size() > 0); t++) begin
            bit took;
            took = 1'b0;
            if (in_ready && in_valid) begin
                sb.push_back(model(a, b, cin));
                if (last_acc >= 0) chk("b2b_interval", cyc - last_acc, ISSUE);
                last_acc = cyc; acc++; took = 1'b1;
            end
            if (out_valid) begin
                pop_check("b2b");
                exp_cnt++;
            end
            tick(); cyc++;
            if (took) begin
                va = va + 4'd3; vb = vb - 4'd5; cin = ~cin;
                a = va; b = vb;
                if (acc == 5) in_valid = 1'b0;
            end
        end
        chk("b2b_drained", sb.size(), 0);
        chk("b2b_accepts", acc, 5);
        chk("b2b_op_count", {24'd0, op_count}, {24'd0, exp_cnt});

        // Exhaustive sweep of every a, b, cin combination
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            run_op(v[3:0], v[7:4], v[8], 1'b0, "sweep");
        end

        // Drive op_count to 255, then check the wrap to zero
        while (exp_cnt != 8'd255) begin
            logic [8:0] r;
            r = 9'($urandom_range(0, 511));
            run_op(r[3:0], r[7:4], r[8], 1'b0, "fill");
        end
        run_op(4'd11, 4'd12, 1'b1, 1'b0, "wrap");
        chk("wrap_zero", {24'd0, op_count}, 32'd0);
        run_op(4'd8, 4'd8, 1'b0, 1'b0, "post_wrap");

        // Reset during the 2nd CALC cycle aborts the operation
        a = 4'd5; b = 4'd6; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = '0;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sum_carry", {27'd0, carry, sum}, 32'd0);
        chk("abort_op_count", {24'd0, op_count}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op(4'd3, 4'd4, 1'b1, 1'b0, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
